// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM arbiter: who owns the read return
// path, and which slot type the arbiter grants in a given cycle.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU
    } owner_t;

    typedef enum logic [2:0] {
        SLOT_NONE,
        SLOT_VGA,
        SLOT_CPU_RD,
        SLOT_DRAIN,
        SLOT_FORCE
    } slot_t;

    localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write buffer: synchronous FIFO of (address, data) pairs. Push is
// ignored when full, pop is ignored when empty.
module vram_wr_fifo #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout reads, CPU reads and posted CPU
// writes share one port; a starvation guard forces buffered writes out.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              has_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [STARVE_W-1:0] starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;
    owner_t            owner;
    slot_t             slot;

    vram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_addr (cpu_addr),
        .push_data (cpu_wdata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign has_data  = (fifo_count != '0);
    assign cpu_busy  = fifo_full;
    assign fifo_push = cpu_we && !fifo_full;

    // A CPU read waits while a write is being posted in the same cycle, so a
    // read never overtakes a store that is still entering the buffer.
    always_comb begin
        slot = SLOT_NONE;
        if (!rst_n)
            slot = SLOT_NONE;
        else if (has_data && starve_cnt == STARVE_W'(STARVE_LIMIT))
            slot = SLOT_FORCE;
        else if (vga_req)
            slot = SLOT_VGA;
        else if (cpu_re && fifo_empty && owner != OWN_CPU && !cpu_we)
            slot = SLOT_CPU_RD;
        else if (has_data)
            slot = SLOT_DRAIN;
    end

    assign fifo_pop = (slot == SLOT_DRAIN) || (slot == SLOT_FORCE);
    assign vga_gnt  = (slot == SLOT_VGA);
    assign vram_we  = fifo_pop;

    always_comb begin
        vram_addr  = '0;
        vram_wdata = '0;
        case (slot)
            SLOT_DRAIN, SLOT_FORCE: begin
                vram_addr  = head_addr;
                vram_wdata = head_data;
            end
            SLOT_VGA:    vram_addr = vga_addr;
            SLOT_CPU_RD: vram_addr = cpu_addr;
            default: begin
                vram_addr  = '0;
                vram_wdata = '0;
            end
        endcase
    end

    // The owner register steers the synchronous-read return one cycle later.
    assign cpu_rvalid = (owner == OWN_CPU);
    assign vga_rvalid = (owner == OWN_VGA);
    assign cpu_rdata  = cpu_rvalid ? vram_rdata : cpu_rdata_q;
    assign vga_rdata  = vga_rvalid ? vram_rdata : vga_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= OWN_NONE;
            starve_cnt  <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            cpu_rdata_q <= cpu_rdata;
            vga_rdata_q <= vga_rdata;
            case (slot)
                SLOT_VGA:    owner <= OWN_VGA;
                SLOT_CPU_RD: owner <= OWN_CPU;
                default:     owner <= OWN_NONE;
            endcase
            if (fifo_pop || !has_data)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a random phase, all checked
// each cycle against a queue-based model of the arbitration rules.
module tb_vram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 8;

    logic              clk;
    logic              rst_n;
    logic              cpu_we;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    int tests    = 0;
    int failures = 0;

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_busy   (cpu_busy),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- VRAM behavioural memory ----------------
    logic [DATA_W-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ref_mem [0:65535];
    int                m_starve;
    int                m_owner;       // 0 none, 1 vga, 2 cpu
    int                m_slot;        // 0 none, 1 vga, 2 cpu read, 3 drain, 4 forced drain
    logic [DATA_W-1:0] m_cpu_pend, m_vga_pend, m_cpu_hold, m_vga_hold;
    bit                m_cpu_known, m_vga_known;
    bit                m_full, m_empty;
    logic [ADDR_W+DATA_W-1:0] m_head;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_starve    = 0;
            m_owner     = 0;
            m_cpu_known = 0;
            m_vga_known = 0;
            chk("rst_vram_we", vram_we, 0);
            chk("rst_vram_addr", vram_addr, 0);
            chk("rst_vram_wdata", vram_wdata, 0);
            chk("rst_cpu_busy", cpu_busy, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_vga_rvalid", vga_rvalid, 0);
            chk("rst_vga_gnt", vga_gnt, 0);
        end else begin
            m_full  = (exp_q.size() == DEPTH);
            m_empty = (exp_q.size() == 0);
            m_head  = m_empty ? '0 : exp_q[0];
            if (!m_empty && m_starve == LIMIT) m_slot = 4;
            else if (vga_req)                  m_slot = 1;
            else if (cpu_re && m_empty && m_owner != 2 && !cpu_we) m_slot = 2;
            else if (!m_empty)                 m_slot = 3;
            else                               m_slot = 0;

            e_addr  = (m_slot >= 3) ? m_head[ADDR_W+DATA_W-1:DATA_W] :
                      (m_slot == 1) ? vga_addr : (m_slot == 2) ? cpu_addr : '0;
            e_wdata = (m_slot >= 3) ? m_head[DATA_W-1:0] : '0;

            chk("vram_we", vram_we, m_slot >= 3);
            chk("vram_addr", vram_addr, e_addr);
            chk("vram_wdata", vram_wdata, e_wdata);
            chk("vga_gnt", vga_gnt, m_slot == 1);
            chk("cpu_busy", cpu_busy, m_full);
            chk("cpu_rvalid", cpu_rvalid, m_owner == 2);
            chk("vga_rvalid", vga_rvalid, m_owner == 1);
            if (m_owner == 2)     chk("cpu_rdata", cpu_rdata, m_cpu_pend);
            else if (m_cpu_known) chk("cpu_rdata_hold", cpu_rdata, m_cpu_hold);
            if (m_owner == 1)     chk("vga_rdata", vga_rdata, m_vga_pend);
            else if (m_vga_known) chk("vga_rdata_hold", vga_rdata, m_vga_hold);

            // advance the model to the next cycle
            if (m_owner == 2) begin m_cpu_hold = m_cpu_pend; m_cpu_known = 1; end
            if (m_owner == 1) begin m_vga_hold = m_vga_pend; m_vga_known = 1; end
            if (m_slot == 1) m_vga_pend = ref_mem[vga_addr];
            if (m_slot == 2) m_cpu_pend = ref_mem[cpu_addr];
            m_owner = (m_slot == 1) ? 1 : (m_slot == 2) ? 2 : 0;
            if (m_empty || m_slot >= 3) m_starve = 0;
            else if (m_starve < LIMIT)  m_starve++;
            if (m_slot >= 3) begin
                ref_mem[m_head[ADDR_W+DATA_W-1:DATA_W]] = m_head[DATA_W-1:0];
                void'(exp_q.pop_front());
            end
            if (cpu_we && !m_full) exp_q.push_back({cpu_addr, cpu_wdata});
        end
    end

    // ---------------- DUT observation for directed pins ----------------
    logic [ADDR_W+DATA_W-1:0] wr_log[$];
    int          vga_gnt_cnt, cpu_rv_cnt, we_cnt, force_vga_cnt;
    bit          force_seen, force_gnt, force_busy;
    logic [ADDR_W-1:0] force_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_we) begin
                wr_log.push_back({vram_addr, vram_wdata});
                we_cnt++;
            end
            if (vga_gnt) vga_gnt_cnt++;
            if (cpu_rvalid) cpu_rv_cnt++;
            if (vram_we && vga_req && !force_seen) begin
                force_seen    = 1;
                force_gnt     = vga_gnt;
                force_busy    = cpu_busy;
                force_addr    = vram_addr;
                force_vga_cnt = vga_gnt_cnt;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int last_wait;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        while (cpu_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            tests++;
            failures++;
            $display("FAIL write_accept_timeout: cpu_busy stuck at 1, expected 0 within 200 cycles");
        end
        last_wait = n;
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] wrap_data [10];
    logic [DATA_W-1:0] got_rdata;
    int                n_wait;
    bit                busy_s, rv_s;

    initial begin
        rst_n = 1'b0; cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 0; vga_addr = '0;
        vga_gnt_cnt = 0; cpu_rv_cnt = 0; we_cnt = 0; force_seen = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // posted writes while idle drain in order
        wr_log.delete();
        cpu_write(16'h0010, 32'hAAAA_0001);
        cpu_write(16'h0011, 32'hAAAA_0002);
        repeat (3) step();
        chk("idle_wr_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("idle_wr0", wr_log[0], {16'h0010, 32'hAAAA_0001});
            chk("idle_wr1", wr_log[1], {16'h0011, 32'hAAAA_0002});
        end

        // fill behind continuous VGA traffic, then starvation forces a drain
        vga_req = 1'b1; vga_addr = 16'h2000;
        vga_gnt_cnt = 0; force_seen = 0;
        for (int i = 0; i < 5; i++) cpu_write(16'h0100 + 16'(i), 32'hBBBB_0000 + 32'(i));
        chk("fifth_write_wait", last_wait, 6);
        vga_req = 1'b0;
        repeat (8) step();
        chk("force_seen", force_seen, 1);
        chk("force_vga_gnt", force_gnt, 0);
        chk("force_cpu_busy", force_busy, 1);
        chk("force_addr", force_addr, 16'h0100);
        chk("force_after_vga", force_vga_cnt, 9);

        // VGA wins over a pending drain; data returns one cycle later
        cpu_write(16'h1200, 32'h0000_F00D);
        repeat (2) step();
        vga_req = 1'b1; vga_addr = 16'h1200;
        cpu_write(16'h0030, 32'hCCCC_0030);
        @(negedge clk);
        chk("vga_pri_gnt", vga_gnt, 1);
        chk("vga_pri_addr", vram_addr, 16'h1200);
        chk("vga_pri_we", vram_we, 0);
        step();
        vga_req = 1'b0;
        @(negedge clk);
        chk("vga_pri_rvalid", vga_rvalid, 1);
        chk("vga_pri_rdata", vga_rdata, 32'h0000_F00D);
        repeat (3) step();

        // read-after-write: the read waits for the buffered store
        cpu_write(16'h0020, 32'h1234_5678);
        cpu_re = 1'b1; cpu_addr = 16'h0020; cpu_rv_cnt = 0;
        n_wait = 0;
        @(negedge clk);
        while (!cpu_rvalid && n_wait < 50) begin
            n_wait++;
            @(negedge clk);
        end
        got_rdata = cpu_rdata;
        step();
        cpu_re = 1'b0;
        repeat (3) step();
        chk("raw_wait_cycles", n_wait, 2);
        chk("raw_rdata", got_rdata, 32'h1234_5678);
        chk("raw_pulses", cpu_rv_cnt, 1);

        // reset with writes buffered
        vga_req = 1'b1; vga_addr = 16'h3000;
        for (int i = 0; i < 3; i++) cpu_write(16'h0200 + 16'(i), $urandom);
        rst_n = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        chk("midrst_busy", cpu_busy, 0);
        step();
        rst_n = 1'b1; we_cnt = 0;
        repeat (5) step();
        chk("midrst_no_stale_we", we_cnt, 0);

        // reset with a CPU read in flight
        cpu_re = 1'b1; cpu_addr = 16'h0020;
        @(negedge clk);
        chk("midrst_rd_grant", vram_addr, 16'h0020);
        step();
        rst_n = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", cpu_rvalid, 0);
        step();
        rst_n = 1'b1; cpu_rv_cnt = 0;
        repeat (4) step();
        chk("midrst_no_pulse", cpu_rv_cnt, 0);

        // pointer wrap: ten write/drain pairs through the small buffer
        wr_log.delete();
        for (int i = 0; i < 10; i++) begin
            wrap_data[i] = $urandom;
            cpu_write(16'h0040 + 16'(i), wrap_data[i]);
            step();
        end
        repeat (2) step();
        chk("wrap_count", wr_log.size(), 10);
        if (wr_log.size() == 10)
            for (int i = 0; i < 10; i++)
                chk($sformatf("wrap_wr%0d", i), wr_log[i], {16'h0040 + 16'(i), wrap_data[i]});

        // random traffic obeying the CPU hold rules
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            busy_s = cpu_busy;
            rv_s   = cpu_rvalid;
            @(posedge clk);
            #1;
            if (!(cpu_we && busy_s)) begin
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = 16'($urandom_range(0, 7));
                cpu_wdata = $urandom;
            end
            if (cpu_re) begin
                if (rv_s) cpu_re = 1'b0;
            end else begin
                cpu_re = ($urandom_range(0, 3) == 0);
            end
            vga_req  = ($urandom_range(0, 9) < 7);
            vga_addr = 16'($urandom_range(0, 7));
        end
        cpu_we = 0; cpu_re = 0; vga_req = 0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the single-port, synchronous-read VRAM between the CPU data path (behind the address decoder's VRAM window) and the VGA scanout fetcher. CPU writes are posted into a small write buffer so stores do not stall. VGA reads have priority, CPU reads come next, and buffered writes drain in free slots. A starvation guard forces a drain slot when the buffer is neglected too long.

Parameters:
ADDR_W, 16, VRAM word-address width.
DATA_W, 32, data word width.
FIFO_DEPTH, 4, posted-write buffer entries; power of two, ≥2.
STARVE_LIMIT, 8, consecutive non-drain cycles with a non-empty buffer before a drain is forced.

Ports:
clk  in  1  system clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
cpu_we  in  1  CPU write request; accepted when cpu_busy=0.
cpu_re  in  1  CPU read request (level, held until cpu_rvalid).
cpu_addr  in  ADDR_W  CPU word address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_busy  out  1  buffer full; CPU must hold cpu_we.
cpu_rdata  out  DATA_W  read data; valid when cpu_rvalid=1.
cpu_rvalid  out  1  one-cycle pulse with read data.
vga_req  in  1  VGA fetch request (level).
vga_addr  in  ADDR_W  VGA word address.
vga_gnt  out  1  VGA slot granted this cycle (combinational).
vga_rdata  out  DATA_W  VGA read data.
vga_rvalid  out  1  pulse one cycle after vga_gnt.
vram_we  out  1  VRAM write enable.
vram_addr  out  ADDR_W  VRAM address.
vram_wdata  out  DATA_W  VRAM write data.
vram_rdata  in  DATA_W  VRAM read data, one cycle after address.

Behaviour:
- Reset: FIFO empty, cpu_busy=0, cpu_rvalid=0, vga_rvalid=0, vram_we=0, vram_addr=0, vram_wdata=0, starve counter=0, owner register=NONE. Reset mid-operation discards buffered writes and in-flight reads; no pulse follows reset release.
- Each cycle grants exactly one slot, in this priority order:
  (1) FORCE_DRAIN when starve counter == STARVE_LIMIT and FIFO non-empty.
  (2) VGA when vga_req.
  (3) CPU_READ when cpu_re, FIFO empty, and no CPU read in flight.
  (4) DRAIN when FIFO non-empty.
  (5) NONE.
- CPU reads are granted only with the FIFO empty. This gives read-after-write ordering without address comparison.
- DRAIN and FORCE_DRAIN: vram_we=1, vram_addr/vram_wdata taken from the FIFO head, head popped.
- VGA and CPU_READ: vram_we=0, vram_addr=requester address. The owner register records the grant type. The next cycle, vram_rdata is routed to the matching rdata output and the matching rvalid is pulsed. Latency is exactly 1 cycle after the grant.
- vga_gnt is high only in a VGA slot. During FORCE_DRAIN, vga_gnt=0 and VGA must hold its request.
- Starve counter: cleared on any drain or when the FIFO is empty; otherwise increments, saturating at STARVE_LIMIT.
- FIFO push when cpu_we && !cpu_busy. cpu_busy = full.
- Simultaneous push and pop when full: the pop frees an entry, but cpu_busy is computed from the registered count (no fall-through), so the push is rejected that cycle.
- Simultaneous push and pop with the FIFO non-full: count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- cpu_re and cpu_we asserted together: the write is accepted first; the read waits until the FIFO is empty.
- cpu_rdata and vga_rdata hold their last value when their rvalid is low.

Decomposition:
- vram_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_VGA, OWN_CPU};
  - slot_t enum {SLOT_NONE, SLOT_VGA, SLOT_CPU_RD, SLOT_DRAIN, SLOT_FORCE};
  - a default STARVE_LIMIT constant.
- One sub-module, vram_wr_fifo: parameterised synchronous FIFO (push, pop, full, empty, head address+data, count). The arbiter instantiates it once.

Test Plan:
- Post writes while idle: cpu_we to 0x0010 (data 0xAAAA0001), then 0x0011 (0xAAAA0002) with vga_req=0 → vram_we=1 with 0x0010/0xAAAA0001 the next cycle, then 0x0011/0xAAAA0002; FIFO returns to empty.
- Fill and stall: 5 back-to-back writes with vga_req=1 held → cpu_busy=1 after 4 accepted; the 5th is held. After 8 cycles, FORCE_DRAIN writes the first entry, vga_gnt=0 that cycle, and the counter clears.
- VGA priority: vga_req=1 at 0x1200 with the FIFO holding 1 entry → vga_gnt=1, vram_addr=0x1200. vram_rdata=0x0000F00D the next cycle → vga_rvalid=1, vga_rdata=0x0000F00D.
- RAW ordering: write 0x0020=0x12345678, then cpu_re at 0x0020 the next cycle → the read is granted only after the drain; cpu_rvalid pulses once with the memory model returning 0x12345678.
- Reset mid-flight: 3 entries buffered and a CPU read granted; rst_n low for one cycle → all outputs at reset values, no cpu_rvalid after release, no stale vram_we.
- Wrap-around: 10 write/drain pairs through a depth-4 FIFO → all 10 VRAM writes appear in order with correct data.
